// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: reads the regfile, forwards from EX/MEM and MEM/WB,
// stalls on load-use hazards and registers the result into ID/EX.
//
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   in_valid/in_rn/in_rm/in_rd     decoded instruction from IF/ID
//   in_reg_write/in_mem_read       instruction controls
//   ReadRegister1/2, ReadData1/2   regfile read port (same-cycle data)
//   exmem_*/memwb_*                forwarding sources
//   flush                          kill the instruction in this stage
//   stall                          hold PC and IF/ID this cycle
//   out_*                          ID/EX pipeline register
module operand_fetch_stage #(
   parameter int WIDTH    = 64,
   parameter int REG_BITS = 5,
   parameter int ZERO_REG = 31
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   input  logic [REG_BITS-1:0] in_rn,
   input  logic [REG_BITS-1:0] in_rm,
   input  logic [REG_BITS-1:0] in_rd,
   input  logic                in_reg_write,
   input  logic                in_mem_read,
   output logic [REG_BITS-1:0] ReadRegister1,
   output logic [REG_BITS-1:0] ReadRegister2,
   input  logic [WIDTH-1:0]    ReadData1,
   input  logic [WIDTH-1:0]    ReadData2,
   input  logic                exmem_reg_write,
   input  logic [REG_BITS-1:0] exmem_rd,
   input  logic [WIDTH-1:0]    exmem_result,
   input  logic                memwb_reg_write,
   input  logic [REG_BITS-1:0] memwb_rd,
   input  logic [WIDTH-1:0]    memwb_result,
   input  logic                flush,
   output logic                stall,
   output logic                out_valid,
   output logic [WIDTH-1:0]    out_op_a,
   output logic [WIDTH-1:0]    out_op_b,
   output logic [REG_BITS-1:0] out_rd,
   output logic                out_reg_write,
   output logic                out_mem_read
);

   localparam logic [REG_BITS-1:0] ZeroIdx = REG_BITS'(ZERO_REG);

   typedef struct packed {
      logic                valid;
      logic [WIDTH-1:0]    opA;
      logic [WIDTH-1:0]    opB;
      logic [REG_BITS-1:0] rd;
      logic                regWrite;
      logic                memRead;
   } idEx_t;

   idEx_t idEx;
   idEx_t idExNext;

   logic [WIDTH-1:0] opA;
   logic [WIDTH-1:0] opB;
   logic             hazard;

   assign ReadRegister1 = in_rn;
   assign ReadRegister2 = in_rm;

   // Hit flags are made mutually exclusive so the select is a true
   // one-hot; EX/MEM outranks MEM/WB as the younger result.
   function automatic logic [WIDTH-1:0] resolve(
      input logic [REG_BITS-1:0] idx,
      input logic [WIDTH-1:0]    rfData,
      input logic                exWr,
      input logic [REG_BITS-1:0] exRd,
      input logic [WIDTH-1:0]    exRes,
      input logic                wbWr,
      input logic [REG_BITS-1:0] wbRd,
      input logic [WIDTH-1:0]    wbRes
   );
      logic zeroHit;
      logic exHit;
      logic wbHit;
      logic [WIDTH-1:0] res;
      zeroHit = (idx == ZeroIdx);
      exHit   = ~zeroHit & exWr
              & (exRd == idx) & (exRd != ZeroIdx);
      wbHit   = ~zeroHit & ~exHit & wbWr
              & (wbRd == idx) & (wbRd != ZeroIdx);
      res = rfData;
      unique case (1'b1)
         zeroHit: res = '0;
         exHit:   res = exRes;
         wbHit:   res = wbRes;
         default: res = rfData;
      endcase
      return res;
   endfunction

   always_comb begin
      opA = resolve(in_rn, ReadData1,
                    exmem_reg_write, exmem_rd, exmem_result,
                    memwb_reg_write, memwb_rd, memwb_result);
      opB = resolve(in_rm, ReadData2,
                    exmem_reg_write, exmem_rd, exmem_result,
                    memwb_reg_write, memwb_rd, memwb_result);
   end

   // A load in ID/EX cannot forward this cycle; a load to XZR
   // produces nothing and so never blocks.
   assign hazard = in_valid & idEx.valid & idEx.memRead
                 & (idEx.rd != ZeroIdx)
                 & ((idEx.rd == in_rn) | (idEx.rd == in_rm));

   assign stall = hazard & ~flush & ~reset;

   always_comb begin
      idExNext          = '0;
      idExNext.valid    = in_valid;
      idExNext.opA      = opA;
      idExNext.opB      = opB;
      idExNext.rd       = in_rd & {REG_BITS{in_valid}};
      idExNext.regWrite = in_reg_write & in_valid;
      idExNext.memRead  = in_mem_read & in_valid;
   end

   // Flush and hazard both load an all-zero bubble.
   always_ff @(posedge clk) begin
      if (reset) begin
         idEx <= '0;
      end else if (flush | hazard) begin
         idEx <= '0;
      end else begin
         idEx <= idExNext;
      end
   end

   assign out_valid     = idEx.valid;
   assign out_op_a      = idEx.opA;
   assign out_op_b      = idEx.opB;
   assign out_rd        = idEx.rd;
   assign out_reg_write = idEx.regWrite;
   assign out_mem_read  = idEx.memRead;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage: forwarding priority,
// XZR handling, load-use stall, flush and reset behaviour.
module tb_operand_fetch_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [4:0]  in_rn, in_rm, in_rd;
   logic        in_reg_write, in_mem_read;
   logic [4:0]  ReadRegister1, ReadRegister2;
   logic [63:0] ReadData1, ReadData2;
   logic        exmem_reg_write;
   logic [4:0]  exmem_rd;
   logic [63:0] exmem_result;
   logic        memwb_reg_write;
   logic [4:0]  memwb_rd;
   logic [63:0] memwb_result;
   logic        flush;
   logic        stall;
   logic        out_valid;
   logic [63:0] out_op_a, out_op_b;
   logic [4:0]  out_rd;
   logic        out_reg_write, out_mem_read;

   int nChecks = 0;
   int nFails  = 0;

   always #5 clk = ~clk;

   operand_fetch_stage dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_rn(in_rn), .in_rm(in_rm),
      .in_rd(in_rd), .in_reg_write(in_reg_write),
      .in_mem_read(in_mem_read),
      .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
      .ReadData1(ReadData1), .ReadData2(ReadData2),
      .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
      .exmem_result(exmem_result),
      .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd),
      .memwb_result(memwb_result),
      .flush(flush), .stall(stall),
      .out_valid(out_valid), .out_op_a(out_op_a),
      .out_op_b(out_op_b), .out_rd(out_rd),
      .out_reg_write(out_reg_write), .out_mem_read(out_mem_read)
   );

   task automatic check(input string tag,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      nChecks++;
      if (got !== exp) begin
         nFails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic instr(input logic v, input logic [4:0] rn,
                        input logic [4:0] rm, input logic [4:0] rd,
                        input logic rw, input logic mr);
      in_valid     = v;
      in_rn        = rn;
      in_rm        = rm;
      in_rd        = rd;
      in_reg_write = rw;
      in_mem_read  = mr;
   endtask

   task automatic noFwd();
      exmem_reg_write = 1'b0;
      exmem_rd        = 5'd0;
      exmem_result    = 64'h0;
      memwb_reg_write = 1'b0;
      memwb_rd        = 5'd0;
      memwb_result    = 64'h0;
   endtask

   initial begin
      reset = 1'b1;
      flush = 1'b0;
      ReadData1 = 64'h0;
      ReadData2 = 64'h0;
      instr(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      noFwd();

      // 1) reset, then XZR read
      tick();
      tick();
      check("rst_valid", 64'(out_valid), 64'h0);
      check("rst_op_a", out_op_a, 64'h0);
      check("rst_op_b", out_op_b, 64'h0);
      check("rst_rd", 64'(out_rd), 64'h0);
      check("rst_rw", 64'(out_reg_write), 64'h0);
      check("rst_mr", 64'(out_mem_read), 64'h0);
      check("rst_stall", 64'(stall), 64'h0);
      reset = 1'b0;
      instr(1'b1, 5'd31, 5'd7, 5'd9, 1'b1, 1'b0);
      ReadData1 = 64'hA0;
      ReadData2 = 64'h33;
      #1;
      check("rdreg1", 64'(ReadRegister1), 64'd31);
      check("rdreg2", 64'(ReadRegister2), 64'd7);
      tick();
      check("xzr_op_a", out_op_a, 64'h0);
      check("xzr_valid", 64'(out_valid), 64'h1);
      check("rf_op_b", out_op_b, 64'h33);
      check("rd_latched", 64'(out_rd), 64'd9);
      check("rw_latched", 64'(out_reg_write), 64'h1);

      // 2) plain regfile read
      instr(1'b1, 5'd3, 5'd0, 5'd1, 1'b1, 1'b0);
      ReadData1 = 64'd5;
      tick();
      check("rf_op_a", out_op_a, 64'd5);
      check("rf_valid", 64'(out_valid), 64'h1);

      // 3) forwarding priority
      instr(1'b1, 5'd4, 5'd4, 5'd1, 1'b1, 1'b0);
      ReadData1 = 64'hDEAD;
      ReadData2 = 64'hBEEF;
      exmem_reg_write = 1'b1; exmem_rd = 5'd4;
      exmem_result = 64'h11;
      memwb_reg_write = 1'b1; memwb_rd = 5'd4;
      memwb_result = 64'h22;
      tick();
      check("fwd_ex_a", out_op_a, 64'h11);
      check("fwd_ex_b", out_op_b, 64'h11);
      exmem_reg_write = 1'b0;
      tick();
      check("fwd_wb_a", out_op_a, 64'h22);
      check("fwd_wb_b", out_op_b, 64'h22);
      // forward from XZR destination must be ignored
      instr(1'b1, 5'd31, 5'd31, 5'd1, 1'b1, 1'b0);
      exmem_reg_write = 1'b1; exmem_rd = 5'd31;
      memwb_rd = 5'd31;
      tick();
      check("fwd_xzr_a", out_op_a, 64'h0);
      check("fwd_xzr_b", out_op_b, 64'h0);
      noFwd();

      // invalid instruction: controls masked
      instr(1'b0, 5'd1, 5'd2, 5'd6, 1'b1, 1'b1);
      tick();
      check("inv_valid", 64'(out_valid), 64'h0);
      check("inv_rw", 64'(out_reg_write), 64'h0);
      check("inv_mr", 64'(out_mem_read), 64'h0);
      check("inv_rd", 64'(out_rd), 64'h0);

      // 4) load-use: LDUR X2 then ADD rm=2
      instr(1'b1, 5'd1, 5'd0, 5'd2, 1'b1, 1'b1);
      tick();
      check("ld_mr", 64'(out_mem_read), 64'h1);
      check("ld_rd", 64'(out_rd), 64'd2);
      instr(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
      ReadData2 = 64'hDEAD;
      #1;
      check("lu_stall", 64'(stall), 64'h1);
      tick();
      check("lu_bub_valid", 64'(out_valid), 64'h0);
      check("lu_bub_rw", 64'(out_reg_write), 64'h0);
      check("lu_bub_mr", 64'(out_mem_read), 64'h0);
      check("lu_stall_drop", 64'(stall), 64'h0);
      memwb_reg_write = 1'b1; memwb_rd = 5'd2;
      memwb_result = 64'h77;
      tick();
      check("lu_add_valid", 64'(out_valid), 64'h1);
      check("lu_add_op_b", out_op_b, 64'h77);
      check("lu_add_rd", 64'(out_rd), 64'd5);
      noFwd();

      // 5) load to XZR never stalls
      instr(1'b1, 5'd1, 5'd1, 5'd31, 1'b1, 1'b1);
      tick();
      instr(1'b1, 5'd31, 5'd0, 5'd6, 1'b1, 1'b0);
      #1;
      check("xzr_ld_stall", 64'(stall), 64'h0);
      tick();
      check("xzr_ld_op_a", out_op_a, 64'h0);
      check("xzr_ld_valid", 64'(out_valid), 64'h1);

      // back-to-back loads: each one checked on its own
      instr(1'b1, 5'd1, 5'd1, 5'd2, 1'b1, 1'b1);
      tick();
      instr(1'b1, 5'd2, 5'd0, 5'd3, 1'b1, 1'b1);
      #1;
      check("b2b_stall1", 64'(stall), 64'h1);
      tick();
      check("b2b_bub1", 64'(out_valid), 64'h0);
      tick();
      check("b2b_ld2_mr", 64'(out_mem_read), 64'h1);
      check("b2b_ld2_rd", 64'(out_rd), 64'd3);
      instr(1'b1, 5'd3, 5'd0, 5'd4, 1'b1, 1'b0);
      #1;
      check("b2b_stall2", 64'(stall), 64'h1);
      tick();
      check("b2b_bub2", 64'(out_valid), 64'h0);

      // 6) flush during hazard
      instr(1'b1, 5'd1, 5'd1, 5'd2, 1'b1, 1'b1);
      tick();
      instr(1'b1, 5'd0, 5'd2, 5'd5, 1'b1, 1'b0);
      flush = 1'b1;
      #1;
      check("fl_stall", 64'(stall), 64'h0);
      tick();
      flush = 1'b0;
      check("fl_valid", 64'(out_valid), 64'h0);
      check("fl_rw", 64'(out_reg_write), 64'h0);
      check("fl_rd", 64'(out_rd), 64'h0);

      // reset during hazard
      instr(1'b1, 5'd1, 5'd1, 5'd2, 1'b1, 1'b1);
      tick();
      instr(1'b1, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0);
      #1;
      check("rh_stall_pre", 64'(stall), 64'h1);
      reset = 1'b1;
      #1;
      check("rh_stall", 64'(stall), 64'h0);
      tick();
      check("rh_valid", 64'(out_valid), 64'h0);
      check("rh_mr", 64'(out_mem_read), 64'h0);
      check("rh_rd", 64'(out_rd), 64'h0);
      reset = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures",
               nChecks, nFails);
      $finish;
   end

endmodule
